// File: rtl/spi_slave.sv
// Mode-0 SPI slave: oversampled SCLK/SS_N/MOSI, rx on SCLK rise, tx on SCLK fall.
// Host loads one tx word per transaction and receives a word plus bit count on deselect.
module spi_slave #(
  parameter int SPI_MAXLEN = 32,
  parameter int CNT_W      = $clog2(SPI_MAXLEN) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_load,
  input  logic [SPI_MAXLEN-1:0] tx_data,
  input  logic [CNT_W-1:0]      tx_len,
  output logic                  tx_ready,
  output logic                  tx_underrun,
  output logic                  rx_valid,
  output logic [SPI_MAXLEN-1:0] rx_data,
  output logic [CNT_W-1:0]      rx_bits,
  output logic                  rx_overflow,
  input  logic                  SCLK,
  input  logic                  SS_N,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  miso_oe
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(SPI_MAXLEN);
  localparam logic [CNT_W:0]   MAX_WIDE = (CNT_W+1)'(SPI_MAXLEN);

  logic sclk_s1, sclk_s2, sclk_s3;
  logic ss_s1, ss_s2, ss_s3;
  logic mosi_s1, mosi_s2;
  logic [1:0] sync_fill_reg;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  state_t                  state_reg, state_next;
  logic                    armed_reg, armed_next;
  logic                    pending_reg, pending_next;
  logic                    had_word_reg, had_word_next;
  logic [SPI_MAXLEN-1:0]   buf_data_reg, buf_data_next;
  logic [CNT_W-1:0]        buf_len_reg, buf_len_next;
  logic [SPI_MAXLEN-1:0]   tx_shift_reg, tx_shift_next;
  logic                    miso_reg, miso_next;
  logic [SPI_MAXLEN-1:0]   rx_shift_reg, rx_shift_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic                    ovf_flag_reg, ovf_flag_next;
  logic [SPI_MAXLEN-1:0]   rx_data_reg, rx_data_next;
  logic [CNT_W-1:0]        rx_bits_reg, rx_bits_next;
  logic                    rx_overflow_reg, rx_overflow_next;
  logic                    rx_valid_reg, rx_valid_next;
  logic                    tx_underrun_reg, tx_underrun_next;

  logic [CNT_W:0]          tx_shamt;
  logic [SPI_MAXLEN-1:0]   tx_aligned;

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;
  assign ss_fall   = ~ss_s2 & ss_s3;
  assign ss_rise   = ss_s2 & ~ss_s3;

  // Left-align the word so MISO is always the MSB and trailing bits shift out as zeros.
  assign tx_shamt   = MAX_WIDE - {1'b0, buf_len_reg};
  assign tx_aligned = buf_data_reg << tx_shamt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {sclk_s1, sclk_s2, sclk_s3} <= 3'b000;
      {ss_s1, ss_s2, ss_s3}       <= 3'b111;
      {mosi_s1, mosi_s2}          <= 2'b00;
      sync_fill_reg   <= '0;
      state_reg       <= IDLE;
      armed_reg       <= 1'b0;
      pending_reg     <= 1'b0;
      had_word_reg    <= 1'b0;
      buf_data_reg    <= '0;
      buf_len_reg     <= '0;
      tx_shift_reg    <= '0;
      miso_reg        <= 1'b0;
      rx_shift_reg    <= '0;
      cnt_reg         <= '0;
      ovf_flag_reg    <= 1'b0;
      rx_data_reg     <= '0;
      rx_bits_reg     <= '0;
      rx_overflow_reg <= 1'b0;
      rx_valid_reg    <= 1'b0;
      tx_underrun_reg <= 1'b0;
    end else begin
      {sclk_s1, sclk_s2, sclk_s3} <= {SCLK, sclk_s1, sclk_s2};
      {ss_s1, ss_s2, ss_s3}       <= {SS_N, ss_s1, ss_s2};
      {mosi_s1, mosi_s2}          <= {MOSI, mosi_s1};
      sync_fill_reg   <= {sync_fill_reg[0], 1'b1};
      state_reg       <= state_next;
      armed_reg       <= armed_next;
      pending_reg     <= pending_next;
      had_word_reg    <= had_word_next;
      buf_data_reg    <= buf_data_next;
      buf_len_reg     <= buf_len_next;
      tx_shift_reg    <= tx_shift_next;
      miso_reg        <= miso_next;
      rx_shift_reg    <= rx_shift_next;
      cnt_reg         <= cnt_next;
      ovf_flag_reg    <= ovf_flag_next;
      rx_data_reg     <= rx_data_next;
      rx_bits_reg     <= rx_bits_next;
      rx_overflow_reg <= rx_overflow_next;
      rx_valid_reg    <= rx_valid_next;
      tx_underrun_reg <= tx_underrun_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    // Only a genuine post-reset high sample arms entry, not the synchronizer reset value.
    armed_next       = armed_reg | (sync_fill_reg[1] & ss_s2);
    pending_next     = pending_reg;
    had_word_next    = had_word_reg;
    buf_data_next    = buf_data_reg;
    buf_len_next     = buf_len_reg;
    tx_shift_next    = tx_shift_reg;
    miso_next        = miso_reg;
    rx_shift_next    = rx_shift_reg;
    cnt_next         = cnt_reg;
    ovf_flag_next    = ovf_flag_reg;
    rx_data_next     = rx_data_reg;
    rx_bits_next     = rx_bits_reg;
    rx_overflow_next = rx_overflow_reg;
    rx_valid_next    = 1'b0;
    tx_underrun_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (ss_fall && armed_reg) begin
          state_next    = ACTIVE;
          cnt_next      = '0;
          ovf_flag_next = 1'b0;
          rx_shift_next = '0;
          had_word_next = pending_reg;
          pending_next  = 1'b0;
          if (pending_reg) begin
            miso_next     = tx_aligned[SPI_MAXLEN-1];
            tx_shift_next = tx_aligned << 1;
          end else begin
            miso_next        = 1'b0;
            tx_shift_next    = '0;
            tx_underrun_next = 1'b1;
          end
        end else if (tx_load) begin
          buf_data_next = tx_data;
          buf_len_next  = tx_len;
          pending_next  = 1'b1;
        end
      end

      ACTIVE: begin
        if (sclk_rise) begin
          rx_shift_next = {rx_shift_reg[SPI_MAXLEN-2:0], mosi_s2};
          if (cnt_reg == MAX_CNT) ovf_flag_next = 1'b1;
          else                    cnt_next      = cnt_reg + 1'b1;
        end
        if (sclk_fall) begin
          miso_next     = tx_shift_reg[SPI_MAXLEN-1];
          tx_shift_next = tx_shift_reg << 1;
        end
        // Exit uses the post-rise values so a coincident last edge is still counted.
        if (ss_rise) begin
          state_next = IDLE;
          miso_next  = 1'b0;
          if (cnt_next != '0) begin
            rx_data_next     = rx_shift_next;
            rx_bits_next     = cnt_next;
            rx_overflow_next = ovf_flag_next;
            rx_valid_next    = 1'b1;
          end else begin
            pending_next = had_word_reg;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign tx_ready    = (state_reg == IDLE);
  assign miso_oe     = (state_reg == ACTIVE);
  assign MISO        = miso_reg;
  assign tx_underrun = tx_underrun_reg;
  assign rx_valid    = rx_valid_reg;
  assign rx_data     = rx_data_reg;
  assign rx_bits     = rx_bits_reg;
  assign rx_overflow = rx_overflow_reg;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged mode-0 master (SCLK half period = 4 clk)
// exercises normal, underrun, overflow, empty-select, reset and ignored-load cases.
module tb_spi_slave;

  localparam int SPI_MAXLEN = 32;
  localparam int CNT_W      = $clog2(SPI_MAXLEN) + 1;

  logic                  clk;
  logic                  rst;
  logic                  tx_load;
  logic [SPI_MAXLEN-1:0] tx_data;
  logic [CNT_W-1:0]      tx_len;
  logic                  tx_ready;
  logic                  tx_underrun;
  logic                  rx_valid;
  logic [SPI_MAXLEN-1:0] rx_data;
  logic [CNT_W-1:0]      rx_bits;
  logic                  rx_overflow;
  logic                  SCLK, SS_N, MOSI, MISO, miso_oe;

  int tests = 0;
  int fails = 0;
  int rxv_cnt = 0;
  int und_cnt = 0;

  spi_slave #(.SPI_MAXLEN(SPI_MAXLEN)) dut (
    .clk(clk), .rst(rst),
    .tx_load(tx_load), .tx_data(tx_data), .tx_len(tx_len), .tx_ready(tx_ready),
    .tx_underrun(tx_underrun), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_bits(rx_bits), .rx_overflow(rx_overflow),
    .SCLK(SCLK), .SS_N(SS_N), .MOSI(MOSI), .MISO(MISO), .miso_oe(miso_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle; an exact count also checks one-cycle width.
  always @(negedge clk) begin
    if (rx_valid === 1'b1)    rxv_cnt++;
    if (tx_underrun === 1'b1) und_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [31:0] d, input int len);
    @(negedge clk);
    tx_data = d; tx_len = CNT_W'(len); tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic ss_low();
    SS_N = 1'b0;
    wait_clk(4);
  endtask

  task automatic ss_high();
    wait_clk(4);
    SS_N = 1'b1;
    wait_clk(6);
  endtask

  task automatic clock_bit(input logic b, output logic m);
    MOSI = b;
    wait_clk(4);
    m = MISO;
    SCLK = 1'b1;
    wait_clk(4);
    SCLK = 1'b0;
  endtask

  task automatic xfer(input int n, input logic [63:0] mosi_w, output logic [63:0] miso_w);
    logic m;
    miso_w = '0;
    ss_low();
    for (int i = n - 1; i >= 0; i--) begin
      clock_bit(mosi_w[i], m);
      miso_w = {miso_w[62:0], m};
    end
    ss_high();
  endtask

  initial begin
    logic [63:0] got;
    logic        m;
    int          rxv0, und0;

    rst = 1'b1; tx_load = 1'b0; tx_data = '0; tx_len = '0;
    SCLK = 1'b0; SS_N = 1'b1; MOSI = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(5);

    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_miso", MISO, 0);
    chk("reset_miso_oe", miso_oe, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_bits", rx_bits, 0);
    chk("reset_rx_overflow", rx_overflow, 0);
    chk("reset_pulses", rxv_cnt + und_cnt, 0);

    // 1: normal 8-bit exchange
    load(32'hA5, 8);
    rxv0 = rxv_cnt; und0 = und_cnt;
    xfer(8, 64'h3C, got);
    $display("[TB] txn1 tx=A5 rx=3C: master got %0h, rx_data=%0h bits=%0d", got, rx_data, rx_bits);
    chk("t1_miso", got, 64'hA5);
    chk("t1_rx_valid", rxv_cnt - rxv0, 1);
    chk("t1_rx_data", rx_data, 32'h3C);
    chk("t1_rx_bits", rx_bits, 8);
    chk("t1_overflow", rx_overflow, 0);
    chk("t1_underrun", und_cnt - und0, 0);
    chk("t1_tx_ready", tx_ready, 1);

    // 2: underrun, 4 bits
    rxv0 = rxv_cnt; und0 = und_cnt;
    xfer(4, 64'hB, got);
    $display("[TB] txn2 underrun rx=B: master got %0h, rx_data=%0h bits=%0d", got, rx_data, rx_bits);
    chk("t2_underrun", und_cnt - und0, 1);
    chk("t2_miso_zero", got, 0);
    chk("t2_rx_valid", rxv_cnt - rxv0, 1);
    chk("t2_rx_data", rx_data, 32'hB);
    chk("t2_rx_bits", rx_bits, 4);

    // 3: 34 clocks overflow
    rxv0 = rxv_cnt;
    xfer(34, 64'h3_FFFF_FFFE, got);
    $display("[TB] txn3 overflow 34 bits: rx_data=%0h bits=%0d ovf=%0d", rx_data, rx_bits, rx_overflow);
    chk("t3_rx_valid", rxv_cnt - rxv0, 1);
    chk("t3_rx_bits", rx_bits, 32);
    chk("t3_overflow", rx_overflow, 1);
    chk("t3_rx_data", rx_data, 32'hFFFF_FFFE);

    // 4: select with no clocks keeps the word pending
    load(32'h55, 8);
    rxv0 = rxv_cnt; und0 = und_cnt;
    ss_low();
    chk("t4_miso_oe_active", miso_oe, 1);
    ss_high();
    $display("[TB] txn4 empty select: rx_valid pulses=%0d", rxv_cnt - rxv0);
    chk("t4_no_rx_valid", rxv_cnt - rxv0, 0);
    chk("t4_rx_data_held", rx_data, 32'hFFFF_FFFE);
    chk("t4_ovf_held", rx_overflow, 1);
    xfer(8, 64'h00, got);
    $display("[TB] txn4b tx=55: master got %0h, bits=%0d", got, rx_bits);
    chk("t4_miso", got, 64'h55);
    chk("t4_underrun", und_cnt - und0, 0);
    chk("t4_rx_valid", rxv_cnt - rxv0, 1);
    chk("t4_overflow_clear", rx_overflow, 0);

    // 5: reset mid-transaction, released while still selected
    load(32'h99, 8);
    rxv0 = rxv_cnt;
    ss_low();
    for (int i = 0; i < 3; i++) clock_bit(1'b1, m);
    @(negedge clk);
    rst = 1'b1;
    wait_clk(2);
    chk("t5_rst_miso_oe", miso_oe, 0);
    chk("t5_rst_miso", MISO, 0);
    rst = 1'b0;
    wait_clk(4);
    chk("t5_post_rst_idle", tx_ready, 1);
    for (int i = 0; i < 5; i++) begin
      clock_bit(1'b1, m);
      chk("t5_no_drive_oe", miso_oe, 0);
      chk("t5_no_drive_miso", m, 0);
    end
    ss_high();
    $display("[TB] txn5 reset mid-txn: rx_valid pulses=%0d rx_bits=%0d", rxv_cnt - rxv0, rx_bits);
    chk("t5_no_rx_valid", rxv_cnt - rxv0, 0);
    chk("t5_rx_bits_reset", rx_bits, 0);
    load(32'hC3, 8);
    xfer(8, 64'h5A, got);
    $display("[TB] txn5b tx=C3 rx=5A: master got %0h, rx_data=%0h", got, rx_data);
    chk("t5_miso", got, 64'hC3);
    chk("t5_rx_data", rx_data, 32'h5A);
    chk("t5_rx_bits", rx_bits, 8);

    // 6: tx_load during a transaction is ignored
    load(32'h77, 8);
    und0 = und_cnt;
    got = '0;
    ss_low();
    chk("t6_tx_ready_low", tx_ready, 0);
    @(negedge clk);
    tx_data = 32'h12; tx_len = CNT_W'(8); tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'(8'h01 >> i), m);
      got = {got[62:0], m};
    end
    ss_high();
    $display("[TB] txn6 load-while-active: master got %0h, rx_data=%0h", got, rx_data);
    chk("t6_miso", got, 64'h77);
    chk("t6_rx_data", rx_data, 32'h01);
    xfer(8, 64'hFF, got);
    $display("[TB] txn6b after ignored load: master got %0h", got);
    chk("t6_not_pending", got, 0);
    chk("t6_underrun", und_cnt - und0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Mode-0 SPI slave: the receiving end of the SPI bus driven by SPIMaster, in the same clk domain family.
- Oversamples SCLK, SS_N and MOSI with clk. Shifts MOSI in on SCLK rising edges and drives MISO out on SCLK falling edges.
- Host side: load a transmit word before a transaction; receive a word plus bit count when SS_N deasserts.
- Used as the bench/loopback partner for SPIMaster and as the slave-side block in peripheral designs.

Parameters:
- SPI_MAXLEN, 32: maximum transaction length in bits; width of tx_data and rx_data.
- CNT_W, $clog2(SPI_MAXLEN)+1: width of tx_len and rx_bits (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- tx_load  in  1  host strobe: latch tx_data/tx_len into the transmit buffer.
- tx_data  in  SPI_MAXLEN  word to send on MISO; first bit is tx_data[tx_len-1].
- tx_len  in  CNT_W  number of valid tx bits, 1..SPI_MAXLEN.
- tx_ready  out  1  high when tx_load will be accepted.
- tx_underrun  out  1  one-cycle pulse: a transaction began with no pending tx word.
- rx_valid  out  1  one-cycle pulse: rx_data/rx_bits updated.
- rx_data  out  SPI_MAXLEN  received bits, LSB = last bit received.
- rx_bits  out  CNT_W  bits received in the transaction, saturating at SPI_MAXLEN.
- rx_overflow  out  1  sticky with rx_valid: more than SPI_MAXLEN rising edges were seen.
- SCLK  in  1  SPI clock from the master (asynchronous).
- SS_N  in  1  slave select, active low (asynchronous).
- MOSI  in  1  master-out data (asynchronous).
- MISO  out  1  slave-out data.
- miso_oe  out  1  MISO output enable; high while the synchronized SS_N is low.

Behaviour:
- Reset values:
  - tx_ready=1; MISO=0; miso_oe=0.
  - rx_valid, tx_underrun, rx_overflow = 0; rx_data=0; rx_bits=0.
  - Tx buffer empty; state IDLE.
  - Synchronizer flops reset to SCLK=0, SS_N=1, MOSI=0.
- Synchronization:
  - Each of SCLK, SS_N and MOSI passes through 2 flops (s1, s2), then a delay flop s3.
  - Edge detects: rise = s2 & !s3; fall = !s2 & s3.
  - An action triggered by a pin edge is registered on the 3rd clk edge after the pin change is first sampled.
- Timing requirement on the master: SCLK high and low phases each >= 4 clk cycles (SPIMaster CLK_DIVIDE >= 8). Faster SCLK is unsupported.
- States:
  - IDLE:
    - tx_ready=1. tx_load latches tx_data/tx_len and sets pending.
    - tx_load while pending overwrites the buffer.
    - ss fall -> ACTIVE.
  - ACTIVE:
    - Entry edge: bit counter=0; tx shift register loaded from the buffer; pending cleared.
    - On entry, MISO = tx_data[tx_len-1]. If no word is pending: MISO=0 and tx_underrun pulses.
    - miso_oe=1; tx_ready=0; tx_load ignored.
    - sclk rise: rx shift <= {rx shift[SPI_MAXLEN-2:0], MOSI_s2}; counter += 1, saturating at SPI_MAXLEN. A rise seen with the counter already at SPI_MAXLEN sets the overflow flag.
    - sclk fall: MISO <= next tx bit. After tx_len bits have been sent, MISO=0.
    - ss rise -> IDLE.
  - Exit (ss rise):
    - If counter > 0: rx_data <= rx shift, rx_bits <= counter, rx_overflow <= flag, rx_valid=1 for 1 cycle.
    - If counter == 0: no rx_valid, and the tx word is restored to pending (not consumed).
    - miso_oe=0 and MISO=0 on the same edge.
- rx_data, rx_bits and rx_overflow hold their values until the next rx_valid.
- Overflow: the rx shift keeps shifting, so rx_data holds the last SPI_MAXLEN bits received.
- Simultaneous events:
  - sclk rise and ss rise on the same cycle: the rise is counted first, then exit is processed.
  - tx_load on the same cycle as ss fall: the load is ignored.
- Reset asserted mid-transaction: everything returns to reset values.
  - After reset is released with SS_N still low (s2=0, s3=1 reset value produces a fall), the block must NOT enter ACTIVE.
  - An arm flag, cleared by reset and set once s2 SS_N is seen high, gates ACTIVE entry.

Test Plan:
- Load tx_data=0xA5, tx_len=8; master sends 8 clocks with MOSI 0x3C (CLK_DIVIDE=8) -> master receives 0xA5; rx_valid one pulse, rx_data=0x3C, rx_bits=8, rx_overflow=0; tx_ready back to 1.
- No tx_load; 4-bit transaction with MOSI 0xB -> tx_underrun pulses once, MISO=0 throughout, rx_data=0xB, rx_bits=4.
- SPI_MAXLEN=32 with 34 clocks, MOSI = 0x3_FFFF_FFFE pattern -> rx_bits=32, rx_overflow=1, rx_data=0xFFFF_FFFE.
- SS_N low then high with no SCLK, pending tx word 0x55 -> no rx_valid, tx word still pending; next 8-bit transaction sends 0x55.
- Assert rst mid-transaction after 3 bits, release with SS_N still low, finish clocks, raise SS_N -> no rx_valid and no MISO drive; next full transaction works normally.
- tx_load=0x12 while SS_N low -> ignored; the transaction sends the word pending at entry; 0x12 is not pending afterwards.
